// File: rtl/axi_lite_arbiter_if.sv
// rtl/axi_lite_arbiter_if.sv - AXI4-Lite bundle (32-bit addr/data) with master/slave views
interface axi_lite_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two-master AXI4-Lite arbiter, one whole transaction at a time
module axi_lite_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic         clk,
    input logic         reset,
    axi_lite_if.slave   m0,
    axi_lite_if.slave   m1,
    axi_lite_if.master  s
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t state, state_next;
    logic   grant, grant_next;
    logic   last_grant, last_grant_next;
    logic   aw_done, aw_done_next;
    logic   w_done, w_done_next;

    logic   g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
    logic   g_arready, g_rvalid, g_awready, g_wready, g_bvalid;
    logic   s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic   req0, req1, pick;

    assign g_arvalid = grant ? m1.arvalid : m0.arvalid;
    assign g_rready  = grant ? m1.rready  : m0.rready;
    assign g_awvalid = grant ? m1.awvalid : m0.awvalid;
    assign g_wvalid  = grant ? m1.wvalid  : m0.wvalid;
    assign g_bready  = grant ? m1.bready  : m0.bready;

    assign req0 = m0.arvalid | m0.awvalid;
    assign req1 = m1.arvalid | m1.awvalid;
    // On a tie round-robin favours whoever did not finish last
    assign pick = (req0 & req1) ? (FIXED_PRIO ? 1'b0 : ~last_grant) : req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
            aw_done    <= aw_done_next;
            w_done     <= w_done_next;
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        aw_done_next    = aw_done;
        w_done_next     = w_done;
        s_arvalid       = 1'b0;
        s_rready        = 1'b0;
        s_awvalid       = 1'b0;
        s_wvalid        = 1'b0;
        s_bready        = 1'b0;
        g_arready       = 1'b0;
        g_rvalid        = 1'b0;
        g_awready       = 1'b0;
        g_wready        = 1'b0;
        g_bvalid        = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    grant_next = pick;
                    state_next = (pick ? m1.arvalid : m0.arvalid) ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: begin
                s_arvalid = g_arvalid;
                g_arready = s.arready;
                if (s_arvalid & s.arready)
                    state_next = RD_DATA;
            end
            RD_DATA: begin
                s_rready = g_rready;
                g_rvalid = s.rvalid;
                if (s.rvalid & g_rready) begin
                    state_next      = IDLE;
                    last_grant_next = grant;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; each is masked once accepted
                s_awvalid    = g_awvalid & ~aw_done;
                s_wvalid     = g_wvalid & ~w_done;
                g_awready    = s.awready & ~aw_done;
                g_wready     = s.wready & ~w_done;
                aw_done_next = aw_done | (s_awvalid & s.awready);
                w_done_next  = w_done | (s_wvalid & s.wready);
                if (aw_done_next & w_done_next) begin
                    state_next   = WR_RESP;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            WR_RESP: begin
                s_bready = g_bready;
                g_bvalid = s.bvalid;
                if (s.bvalid & g_bready) begin
                    state_next      = IDLE;
                    last_grant_next = grant;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s.araddr  = grant ? m1.araddr : m0.araddr;
    assign s.awaddr  = grant ? m1.awaddr : m0.awaddr;
    assign s.wdata   = grant ? m1.wdata  : m0.wdata;
    assign s.wstrb   = grant ? m1.wstrb  : m0.wstrb;
    assign s.arvalid = s_arvalid;
    assign s.rready  = s_rready;
    assign s.awvalid = s_awvalid;
    assign s.wvalid  = s_wvalid;
    assign s.bready  = s_bready;

    assign m0.arready = g_arready & ~grant;
    assign m0.rvalid  = g_rvalid  & ~grant;
    assign m0.awready = g_awready & ~grant;
    assign m0.wready  = g_wready  & ~grant;
    assign m0.bvalid  = g_bvalid  & ~grant;
    assign m1.arready = g_arready & grant;
    assign m1.rvalid  = g_rvalid  & grant;
    assign m1.awready = g_awready & grant;
    assign m1.wready  = g_wready  & grant;
    assign m1.bvalid  = g_bvalid  & grant;

    assign m0.rdata = s.rdata;
    assign m0.rresp = s.rresp;
    assign m0.bresp = s.bresp;
    assign m1.rdata = s.rdata;
    assign m1.rresp = s.rresp;
    assign m1.bresp = s.bresp;
endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master, one-slave AXI4-Lite arbiter that shares a single downstream AXI4-Lite port between the instruction fetch unit (master 0) and the load/store unit (master 1). It sits between the core's fetch/LSU ports and the downstream slave (memory, CLINT or an address crossbar). It grants one complete transaction (read or write) at a time and uses round-robin or fixed priority.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin between m0/m1 on simultaneous requests; 1 = m0 always wins ties.
- `clk` input 1: single clock, all state on posedge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `m0` axi_lite_if.slave, bundle: upstream port from the fetch unit (32-bit addr/data, 2-bit resp).
- `m1` axi_lite_if.slave, bundle: upstream port from the LSU.
- `s` axi_lite_if.master, bundle: downstream port to the shared slave.

## Operation
- State machine states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; registers `grant` (0=m0, 1=m1), `last_grant`, `aw_done`, `w_done`.
- A master requests when `arvalid | awvalid`.
- IDLE: if any master requests, latch `grant`, then go to RD_ADDR if the granted master has `arvalid`, else go to WR_REQ. Read has priority over write inside one master.
- Tie (both request): FIXED_PRIO=1 grants m0. FIXED_PRIO=0 grants the master ≠ `last_grant`. `last_grant` updates to `grant` when a transaction completes.
- RD_ADDR: `s.arvalid = gm.arvalid`, `s.araddr = gm.araddr`, `gm.arready = s.arready`. On the s AR handshake, go to RD_DATA.
- RD_DATA: `gm.rvalid = s.rvalid`, `gm.rdata/rresp = s.rdata/rresp`, `s.rready = gm.rready`. On the R handshake, go to IDLE.
- WR_REQ: AW and W are forwarded independently.
  - `s.awvalid = gm.awvalid & ~aw_done`, `s.wvalid = gm.wvalid & ~w_done`.
  - `gm.awready = s.awready & ~aw_done`, `gm.wready = s.wready & ~w_done`.
  - `aw_done`/`w_done` set on their handshakes.
  - When both are done (including both in the same cycle), go to WR_RESP and clear both flags.
- WR_RESP: `gm.bvalid = s.bvalid`, `gm.bresp = s.bresp`, `s.bready = gm.bready`. On the B handshake, go to IDLE.
- Non-granted master and all states not listed above: all of its ready/valid outputs are 0. Data/addr/resp outputs are don't-care but driven from `s` (no X).
- `s` addr/data/strb fields are muxed from the granted master in every state. `s` valid/ready outputs are 0 in IDLE.
- Exactly one transaction is outstanding downstream. No interleaving, no reordering.
- Reset (asynchronous, including mid-transaction):
  - state=IDLE, grant=0, last_grant=1, aw_done=w_done=0.
  - All valid/ready outputs on all ports go to 0 immediately, without waiting for a clock.
  - An in-flight transaction is dropped; the downstream slave is reset by the same reset.

## Timing
- Arbitration costs 1 cycle: request seen in IDLE at cycle N; `s.arvalid`/`s.awvalid` asserted in cycle N+1.
- After grant, every channel is a zero-latency combinational pass-through (no extra register stages on handshakes).
- Back-to-back: after the final R/B handshake at cycle M, state is IDLE at M+1, and the next grant becomes visible downstream at M+2.
- Minimum read cost with a 1-cycle slave: 3 cycles per transaction (IDLE, RD_ADDR, RD_DATA).
- A master dropping `arvalid` before handshake is an AXI violation; behaviour is undefined but must not deadlock past reset.
- Requests from the non-granted master are held off (ready=0) until the arbiter returns to IDLE. They are never lost, because valid stays high.

## Test plan
- Single read from m0: m0.araddr=0x0a000048 at cycle 0, slave returns rdata=0x1234 with rresp=00 → s.arvalid is high in cycle 1, and m0 sees rvalid with rdata=0x1234. m1 outputs stay at 0 throughout.
- Simultaneous reads with FIXED_PRIO=0:
  - Both m0 and m1 assert arvalid continuously; grant order is m0, m1, m0, m1 across 4 transactions.
  - With FIXED_PRIO=1, m0 wins every tie while it keeps requesting, and m1 waits.
- Write with W before AW:
  - m1 presents wvalid (wdata=0xdeadbeef) 2 cycles before awvalid (awaddr=0x80000000). The slave sees both; exactly one B handshake reaches m1 with the slave's bresp (e.g. 10).
  - Repeat with AW and W accepted in the same cycle; WR_RESP is reached on the next cycle.
- One master with both requests: m0 asserts arvalid and awvalid together → the read completes first, then the write is granted from IDLE (round-robin permitting).
- Backpressure: the slave holds arready=0 for 5 cycles and rvalid for 3 cycles with m0.rready=0 → no handshakes are duplicated, and data stays stable until the handshake.
- Reset in RD_DATA: assert reset asynchronously mid-cycle → all valid/ready outputs drop to 0 before the next clk edge. After release, m0 wins the first tie (last_grant=1).
